// File: rtl/parity_stream_scheduler_pkg.sv
// rtl/parity_stream_scheduler_pkg.sv - shared constants and FSM encoding for the parity stream scheduler
package parity_pkg;

    localparam logic [7:0] CH_0           = 8'h30;
    localparam logic [7:0] CH_1           = 8'h31;
    localparam logic [7:0] CH_SP          = 8'h20;
    localparam int         CHARS_PER_WORD = 4;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        CLEAR,
        FEED,
        DRAIN,
        RESP
    } state_t;

endpackage

// File: rtl/parity_stream_scheduler_if.sv
// rtl/parity_stream_scheduler_if.sv - requester request/response bus
interface parity_stream_scheduler_if #(
    parameter int NREQ = 4
);
    localparam int IW = $clog2(NREQ);

    logic [NREQ-1:0]    req;
    logic [NREQ*32-1:0] req_data;
    logic [NREQ-1:0]    gnt;
    logic               rsp_valid;
    logic [IW-1:0]      rsp_id;
    logic [31:0]        rsp_data;
    logic               rsp_ready;

    modport master (
        output req, req_data, rsp_ready,
        input  gnt, rsp_valid, rsp_id, rsp_data
    );

    modport slave (
        input  req, req_data, rsp_ready,
        output gnt, rsp_valid, rsp_id, rsp_data
    );
endinterface

// File: rtl/parity_stream_scheduler_rr_arbiter.sv
// rtl/parity_stream_scheduler_rr_arbiter.sv - combinational round-robin pick starting at ptr
module rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] win,
    output logic [IW-1:0]   win_idx
);

    // scan from the farthest index back to ptr so the nearest set request overrides
    always_comb begin
        win     = '0;
        win_idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[(int'(ptr) + i) % NREQ]) begin
                win                               = '0;
                win[(int'(ptr) + i) % NREQ]       = 1'b1;
                win_idx                           = IW'((int'(ptr) + i) % NREQ);
            end
        end
    end

endmodule

// File: rtl/parity_stream_scheduler.sv
// rtl/parity_stream_scheduler.sv - shares one character-serial parity generator among NREQ requesters
module parity_stream_scheduler
    import parity_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int PG_LAT = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    parity_stream_scheduler_if.slave    bus,
    output logic                        pg_clr,
    output logic                        pg_valid,
    output logic [7:0]                  pg_in,
    input  logic [7:0]                  pg_out
);

    localparam int IW = $clog2(NREQ);

    state_t          state, state_nx;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   idx_q;
    logic [NREQ-1:0] win_q;
    logic [NREQ-1:0] arb_win;
    logic [IW-1:0]   arb_idx;
    logic [31:0]     word_q;
    logic [31:0]     shift_q;
    logic [2:0]      el;
    logic [2:0]      cap_cnt;
    logic            cap_en;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req     (bus.req),
        .ptr     (ptr),
        .win     (arb_win),
        .win_idx (arb_idx)
    );

    // pg_out lags pg_in by PG_LAT, so capture opens PG_LAT cycles into FEED
    assign cap_en = ((state == FEED) || (state == DRAIN))
                    && (int'(el) >= PG_LAT)
                    && (cap_cnt < 3'(CHARS_PER_WORD));

    assign bus.rsp_id   = idx_q;
    assign bus.rsp_data = shift_q;

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // next state and per-state outputs
    always_comb begin
        state_nx      = state;
        pg_clr        = 1'b0;
        pg_valid      = 1'b0;
        pg_in         = CH_SP;
        bus.gnt       = '0;
        bus.rsp_valid = 1'b0;
        case (state)
            IDLE:  if (|bus.req) state_nx = GRANT;
            GRANT: begin
                bus.gnt  = win_q;
                state_nx = CLEAR;
            end
            CLEAR: begin
                pg_clr   = 1'b1;
                state_nx = FEED;
            end
            FEED: begin
                pg_valid = 1'b1;
                pg_in    = word_q[31:24];
                if (el == 3'd3) state_nx = (PG_LAT == 0) ? RESP : DRAIN;
            end
            DRAIN: if (el == 3'(3 + PG_LAT)) state_nx = RESP;
            RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // winner latch, pointer advance, word latch and feed/drain cycle counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr    <= '0;
            idx_q  <= '0;
            win_q  <= '0;
            word_q <= {4{CH_SP}};
            el     <= '0;
        end else begin
            case (state)
                IDLE: if (|bus.req) begin
                    win_q <= arb_win;
                    idx_q <= arb_idx;
                end
                GRANT: begin
                    word_q <= bus.req_data[32*idx_q +: 32];
                    ptr    <= (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + 1'b1;
                end
                CLEAR: el <= '0;
                FEED: begin
                    word_q <= {word_q[23:0], CH_SP};
                    el     <= el + 3'd1;
                end
                DRAIN: el <= el + 3'd1;
                default: ;
            endcase
        end
    end

    // result shift register, first captured character ends up in [31:24]
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q <= {4{CH_SP}};
            cap_cnt <= '0;
        end else if (state == CLEAR) begin
            cap_cnt <= '0;
        end else if (cap_en) begin
            shift_q <= {shift_q[23:0], pg_out};
            cap_cnt <= cap_cnt + 3'd1;
        end
    end

endmodule

// File: tb/tb_parity_stream_scheduler.sv
// tb/tb_parity_stream_scheduler.sv - randomized self-checking bench for parity_stream_scheduler
module tb_parity_stream_scheduler;

    localparam int NREQ = 4;
    localparam int LAT  = 1;
    localparam int RK   = 6 + LAT;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    parity_stream_scheduler_if #(.NREQ(NREQ)) bus  ();
    parity_stream_scheduler_if #(.NREQ(NREQ)) bus0 ();
    parity_stream_scheduler_if #(.NREQ(NREQ)) bus3 ();

    logic       pg_clr,  pg_valid;
    logic [7:0] pg_in,   pg_out;
    logic       pg_clr0, pg_valid0;
    logic [7:0] pg_in0,  pg_out0;
    logic       pg_clr3, pg_valid3;
    logic [7:0] pg_in3,  pg_out3;

    parity_stream_scheduler #(.NREQ(NREQ), .PG_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .pg_clr(pg_clr), .pg_valid(pg_valid), .pg_in(pg_in), .pg_out(pg_out)
    );
    parity_stream_scheduler #(.NREQ(NREQ), .PG_LAT(0)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0),
        .pg_clr(pg_clr0), .pg_valid(pg_valid0), .pg_in(pg_in0), .pg_out(pg_out0)
    );
    parity_stream_scheduler #(.NREQ(NREQ), .PG_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .bus(bus3),
        .pg_clr(pg_clr3), .pg_valid(pg_valid3), .pg_in(pg_in3), .pg_out(pg_out3)
    );

    // generator models: plain delay lines of the fed characters
    logic [7:0] d1;
    logic [7:0] d3 [3];
    always @(posedge clk) begin
        d1    <= pg_in;
        d3[0] <= pg_in3;
        d3[1] <= d3[0];
        d3[2] <= d3[1];
    end
    assign pg_out  = d1;
    assign pg_out0 = pg_in0;
    assign pg_out3 = d3[2];

    int n_checks = 0;
    int n_errors = 0;
    int mptr     = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int model_pick(input logic [NREQ-1:0] m, input int p);
        for (int i = 0; i < NREQ; i++)
            if (m[(p + i) % NREQ]) return (p + i) % NREQ;
        return -1;
    endfunction

    function automatic logic [7:0] rand_char();
        case ($urandom_range(0, 4))
            0:       return 8'h30;
            1:       return 8'h31;
            2:       return 8'h20;
            default: return 8'($urandom_range(33, 126));
        endcase
    endfunction

    function automatic logic [127:0] rand_lanes();
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = rand_char();
        return r;
    endfunction

    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, "_gnt"},       32'(bus.gnt),       32'h0);
        check_eq({pfx, "_rsp_valid"}, 32'(bus.rsp_valid), 32'h0);
        check_eq({pfx, "_rsp_id"},    32'(bus.rsp_id),    32'h0);
        check_eq({pfx, "_rsp_data"},  bus.rsp_data,       32'h20202020);
        check_eq({pfx, "_pg_clr"},    32'(pg_clr),        32'h0);
        check_eq({pfx, "_pg_valid"},  32'(pg_valid),      32'h0);
        check_eq({pfx, "_pg_in"},     32'(pg_in),         32'h20);
    endtask

    // one full transaction on the main DUT; called at a negedge with the DUT idle
    task automatic run_txn(input logic [NREQ-1:0] mask, input logic [NREQ-1:0] mask_after,
                           input int stall, input logic [127:0] data);
        int          w;
        logic [31:0] word;
        bit          got;
        bit          feed;
        w             = model_pick(mask, mptr);
        word          = data[32*w +: 32];
        bus.req_data  = data;
        bus.req       = mask;
        bus.rsp_ready = (stall == 0);
        got = 1'b0;
        for (int t = 0; t < 10 && !got; t++) begin
            @(negedge clk);
            if (bus.gnt != '0) got = 1'b1;
        end
        if (!got) check_eq("gnt_wait", 32'h0, 32'h1);
        for (int k = 0; k < RK; k++) begin
            if (k > 0) @(negedge clk);
            feed = (k >= 2) && (k <= 5);
            check_eq("gnt", 32'(bus.gnt), (k == 0) ? (32'h1 << w) : 32'h0);
            check_eq("pg_clr", 32'(pg_clr), 32'(k == 1));
            check_eq("pg_valid", 32'(pg_valid), 32'(feed));
            check_eq("pg_in", 32'(pg_in), feed ? ((word >> (8 * (5 - k))) & 32'hFF) : 32'h20);
            check_eq("rsp_early", 32'(bus.rsp_valid), 32'h0);
            if (k == 0) bus.req = mask_after;
        end
        @(negedge clk);
        check_eq("rsp_valid", 32'(bus.rsp_valid), 32'h1);
        check_eq("rsp_id", 32'(bus.rsp_id), 32'(w));
        check_eq("rsp_data", bus.rsp_data, word);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check_eq("hold_valid", 32'(bus.rsp_valid), 32'h1);
            check_eq("hold_id", 32'(bus.rsp_id), 32'(w));
            check_eq("hold_data", bus.rsp_data, word);
            check_eq("hold_gnt", 32'(bus.gnt), 32'h0);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check_eq("rsp_done", 32'(bus.rsp_valid), 32'h0);
        mptr = (w + 1) % NREQ;
    endtask

    initial begin : stim
        logic [127:0] lanes;
        int           g0, g3, r0, r3;
        logic [31:0]  dat0, dat3;
        bit           got;

        rst = 1'b0;
        bus.req  = '0; bus.req_data  = '0; bus.rsp_ready  = 1'b1;
        bus0.req = '0; bus0.req_data = '0; bus0.rsp_ready = 1'b1;
        bus3.req = '0; bus3.req_data = '0; bus3.rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_eq("idle_gnt", 32'(bus.gnt), 32'h0);
        end

        // all requesters held: strict rotation 0,1,2,3,0
        for (int i = 0; i < 5; i++) run_txn(4'b1111, 4'b1111, 0, rand_lanes());

        // single requester with the example word
        lanes = rand_lanes();
        lanes[31:0] = "010 ";
        run_txn(4'b0001, 4'b0001, 0, lanes);

        // response stalled five cycles with other requests waiting, then 0010 next
        run_txn(4'b0001, 4'b0110, 5, rand_lanes());
        run_txn(4'b0110, 4'b0000, 0, rand_lanes());

        // randomized traffic with idle gaps, late request changes and stalls
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                bus.req = '0;
                repeat (2) begin
                    @(negedge clk);
                    check_eq("gap_gnt", 32'(bus.gnt), 32'h0);
                end
            end
            run_txn(4'($urandom_range(1, 15)), 4'($urandom_range(0, 15)),
                    $urandom_range(0, 3), rand_lanes());
        end

        // reset in cycle G+3 aborts the transaction and rewinds the pointer
        bus.req_data = rand_lanes();
        bus.req      = 4'b0100;
        got = 1'b0;
        for (int t = 0; t < 10 && !got; t++) begin
            @(negedge clk);
            if (bus.gnt != '0) got = 1'b1;
        end
        check_eq("abort_gnt_seen", 32'(got), 32'h1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_outputs("midrst");
        bus.req = 4'b1010;
        repeat (2) begin
            @(negedge clk);
            check_eq("midrst_valid", 32'(bus.rsp_valid), 32'h0);
            check_eq("midrst_gnt", 32'(bus.gnt), 32'h0);
        end
        rst  = 1'b1;
        mptr = 0;
        run_txn(4'b1010, 4'b0000, 0, rand_lanes());

        // latency of the PG_LAT=0 and PG_LAT=3 builds
        lanes = rand_lanes();
        lanes[31:0] = "111 ";
        bus0.req_data = lanes; bus3.req_data = lanes;
        bus0.req = 4'b0001;    bus3.req = 4'b0001;
        g0 = -1; g3 = -1; r0 = -1; r3 = -1; dat0 = '0; dat3 = '0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (g0 < 0 && bus0.gnt != '0) begin g0 = c; bus0.req = '0; end
            if (g3 < 0 && bus3.gnt != '0) begin g3 = c; bus3.req = '0; end
            if (r0 < 0 && bus0.rsp_valid) begin r0 = c; dat0 = bus0.rsp_data; end
            if (r3 < 0 && bus3.rsp_valid) begin r3 = c; dat3 = bus3.rsp_data; end
        end
        check_eq("lat0_gnt_seen", 32'(g0 >= 0), 32'h1);
        check_eq("lat3_gnt_seen", 32'(g3 >= 0), 32'h1);
        check_eq("lat0_cycles", 32'(r0 - g0), 32'd6);
        check_eq("lat3_cycles", 32'(r3 - g3), 32'd9);
        check_eq("lat0_data", dat0, "111 ");
        check_eq("lat3_data", dat3, "111 ");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
